apb_master_bridge: RTL
======================

# apb_master_bridge

APB initiator that turns single-command requests from the accelerator's host-side sequencer into APB3/APB4 transfers toward the matrix-multiplier register slave. Address map on `paddr_o[2:0]`: 0 = control register, 1 = Matrix A, 2 = Matrix B, 3 = flags register, 4–7 = scratchpad (SP). The block owns the SETUP/ACCESS sequencing, PREADY wait states and a wait-state timeout, and returns read data and error status on a response handshake.

## Interface
- `DATA_WIDTH`, 32, APB data width; multiple of 8.
- `ADDR_WIDTH`, 32, APB address width; ≥ 3.
- `TIMEOUT`, 255, maximum ACCESS cycles with PREADY low before forced termination; ≥ 1.
- `clk_i` in 1: the block's single clock.
- `rst_ni` in 1: reset, synchronous and active-low.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: block can accept a command.
- `cmd_write_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` in ADDR_WIDTH: target address.
- `cmd_wdata_i` in DATA_WIDTH: write data.
- `cmd_strb_i` in DATA_WIDTH/8: byte strobes for writes.
- `psel_o`, `penable_o`, `pwrite_o` out 1: APB control.
- `paddr_o` out ADDR_WIDTH, `pwdata_o` out DATA_WIDTH, `pstrb_o` out DATA_WIDTH/8: APB payload.
- `pready_i`, `pslverr_i` in 1; `prdata_i` in DATA_WIDTH: APB completer response.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: response consumed.
- `rsp_rdata_o` out DATA_WIDTH: captured read data; 0 for writes.
- `rsp_slverr_o` out 1: completer signalled PSLVERR.
- `rsp_timeout_o` out 1: transfer terminated by timeout.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `cmd_ready_o`=1. On `cmd_valid_i && cmd_ready_o` register write/addr/wdata/strb, go SETUP.
- SETUP: `psel_o`=1, `penable_o`=0, payload from registers; unconditionally go ACCESS.
- ACCESS: `psel_o`=1, `penable_o`=1, payload held stable. Wait counter increments each cycle with `pready_i`=0.
  - `pready_i`=1: capture `prdata_i` (reads only; writes capture 0), capture `pslverr_i`, timeout flag 0, go RESP.
  - Counter reaches TIMEOUT with `pready_i` still 0: `rsp_timeout_o` set, `rsp_slverr_o`=1, rdata 0, go RESP. PREADY and TIMEOUT in same cycle: PREADY wins.
- RESP: `psel_o`=`penable_o`=0, `rsp_valid_o`=1, response stable; on `rsp_ready_i` go IDLE.
- Reads drive `pstrb_o`=0 and `pwdata_o`=0; writes drive registered strobe/data.
- `cmd_ready_o` is 0 outside IDLE; one outstanding transfer max.
- `pwrite_o`, `paddr_o` hold last values in IDLE/RESP (no toggling between transfers).

## Timing
- Reset (`rst_ni`=0 at a rising edge): state IDLE, counter 0; all outputs 0 except `cmd_ready_o`=1 from the first cycle after reset release.
- Reset mid-transfer: `psel_o`/`penable_o` low after that edge; transfer abandoned, no response issued.
- Zero-wait-state transfer: accept at cycle N, SETUP N+1, ACCESS N+2 (PREADY sampled high), `rsp_valid_o` N+3. With `rsp_ready_i` high at N+3, IDLE at N+4, next accept at N+4; minimum 4 cycles per transfer.
- Each wait state adds one ACCESS cycle. Timeout: ACCESS lasts exactly TIMEOUT+1 cycles, RESP next.
- Counter width ceil(log2(TIMEOUT+1)); cleared on entry to SETUP; never wraps.
- `pslverr_i` and `prdata_i` sampled only on the ACCESS cycle with `pready_i`=1.

## Test plan
- Zero-wait write to addr 0x0, wdata 0x0000_0001, strb 0xF -> SETUP/ACCESS one cycle each, `pwrite_o`=1, `pstrb_o`=0xF, `rsp_valid_o` 3 cycles after accept, `rsp_rdata_o`=0, no errors.
- Read addr 0x3 with completer holding PREADY low 3 cycles, `prdata_i`=0xDEAD_BEEF -> ACCESS 4 cycles, paddr stable, `pstrb_o`=0, `rsp_rdata_o`=0xDEAD_BEEF.
- Read addr 0x4 with PSLVERR=1 on completion -> `rsp_slverr_o`=1, `rsp_timeout_o`=0.
- TIMEOUT=4, PREADY never asserted -> ACCESS 5 cycles, then `rsp_timeout_o`=1, `rsp_slverr_o`=1, `rsp_rdata_o`=0.
- Response backpressure: `rsp_ready_i` low 5 cycles -> response held stable, `cmd_ready_o`=0, no new SETUP; back-to-back writes to 0x1 then 0x2 otherwise 4 cycles apart.
- `rst_ni` low during ACCESS -> next cycle `psel_o`=`penable_o`=0, `rsp_valid_o`=0, `cmd_ready_o`=1 after release.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Command, APB and response signals of the APB master bridge.
// The master modport is the bridge's view; slave is the sequencer/completer side.
interface apb_master_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;
    logic [STRB_W-1:0]     cmd_strb_i;

    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [STRB_W-1:0]     pstrb_o;
    logic                  pready_i;
    logic                  pslverr_i;
    logic [DATA_WIDTH-1:0] prdata_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_slverr_o;
    logic                  rsp_timeout_o;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        output cmd_ready_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        input  pready_i, pslverr_i, prdata_i,
        output rsp_valid_o, rsp_rdata_o, rsp_slverr_o, rsp_timeout_o,
        input  rsp_ready_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        input  cmd_ready_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        output pready_i, pslverr_i, prdata_i,
        input  rsp_valid_o, rsp_rdata_o, rsp_slverr_o, rsp_timeout_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: command in, SETUP/ACCESS with wait-state
// timeout, response out. All outputs are registered state of one FSM.
module apb_master_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    apb_master_bridge_if.master bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    if (DATA_WIDTH % 8 != 0 || ADDR_WIDTH < 3 || TIMEOUT < 1) begin : g_bad_params
        $error("apb_master_bridge: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  cmd_ready;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_W-1:0]     pstrb;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_slverr;
    logic                  rsp_timeout;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready is high throughout IDLE, so valid alone is the handshake
                    if (bus.cmd_valid_i) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        wait_cnt  <= '0;
                        pwrite    <= bus.cmd_write_i;
                        paddr     <= bus.cmd_addr_i;
                        pwdata    <= bus.cmd_write_i ? bus.cmd_wdata_i : '0;
                        pstrb     <= bus.cmd_write_i ? bus.cmd_strb_i  : '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    // PREADY is checked first so it wins over an expiring counter
                    if (bus.pready_i) begin
                        state       <= RESP;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : bus.prdata_i;
                        rsp_slverr  <= bus.pslverr_i;
                        rsp_timeout <= 1'b0;
                    end else if (wait_cnt == CNT_MAX) begin
                        state       <= RESP;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_slverr  <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o   = cmd_ready;
    assign bus.psel_o        = psel;
    assign bus.penable_o     = penable;
    assign bus.pwrite_o      = pwrite;
    assign bus.paddr_o       = paddr;
    assign bus.pwdata_o      = pwdata;
    assign bus.pstrb_o       = pstrb;
    assign bus.rsp_valid_o   = rsp_valid;
    assign bus.rsp_rdata_o   = rsp_rdata;
    assign bus.rsp_slverr_o  = rsp_slverr;
    assign bus.rsp_timeout_o = rsp_timeout;
endmodule
